// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch write controller: FSM state encoding
// and a helper that sizes the round-robin pointer.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4
    } state_e;

    // Pointer/index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]          req_i,
    input  logic [ptr_w(NREQ)-1:0]   ptr_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [ptr_w(NREQ)-1:0]   idx_o
);

    localparam int unsigned PW = ptr_w(NREQ);

    logic        found;
    int unsigned k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr_i) + i) % NREQ;
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = PW'(k);
            end
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin write controller for a D-latch bank: each write runs
// SETUP -> PULSE -> HOLD so d is stable around the single-cycle enable.
module latch_write_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned NLAT = 8,
    parameter int unsigned AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 clr,
    output logic [NREQ-1:0]      gnt,
    output logic                 clr_done,
    output logic [DW-1:0]        latch_d,
    output logic [NLAT-1:0]      latch_en,
    output logic                 latch_rst,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned PW = ptr_w(NREQ);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic              clr_pend_q, clr_pend_d;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NLAT-1:0]   latch_en_q, latch_en_d;
    logic              clr_done_q, clr_done_d;
    logic              latch_rst_q, latch_rst_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   arb_grant;
    logic [PW-1:0]     arb_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // Outputs are derived from the state being entered so that every
    // registered output lines up with the cycle its state is occupied.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        addr_d     = addr_q;
        data_d     = data_q;
        clr_pend_d = clr_pend_q | clr;

        unique case (state_q)
            IDLE: begin
                if (clr_pend_q || clr) begin
                    state_d = CLEAR;
                end else if (|arb_grant) begin
                    state_d = SETUP;
                    win_d   = arb_idx;
                    addr_d  = req_addr[arb_idx*AW +: AW];
                    data_d  = req_data[arb_idx*DW +: DW];
                end
            end
            SETUP:   state_d = PULSE;
            PULSE:   state_d = HOLD;
            HOLD: begin
                state_d = IDLE;
                ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == CLEAR) clr_pend_d = 1'b0;

        gnt_d      = '0;
        latch_en_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt_d[i] = (state_d == HOLD) && (win_q == PW'(i));
        end
        // Out-of-range addresses match no bit, so no enable is driven.
        for (int unsigned i = 0; i < NLAT; i++) begin
            latch_en_d[i] = (state_d == PULSE) && (32'(addr_q) == i);
        end
        err_d       = (state_d == HOLD) && (32'(addr_q) >= NLAT);
        clr_done_d  = (state_d == CLEAR);
        latch_rst_d = (state_d == CLEAR);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            clr_pend_q  <= 1'b0;
            gnt_q       <= '0;
            latch_en_q  <= '0;
            clr_done_q  <= 1'b0;
            latch_rst_q <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            clr_pend_q  <= clr_pend_d;
            gnt_q       <= gnt_d;
            latch_en_q  <= latch_en_d;
            clr_done_q  <= clr_done_d;
            latch_rst_q <= latch_rst_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign clr_done  = clr_done_q;
    assign latch_d   = data_q;
    assign latch_en  = latch_en_q;
    assign latch_rst = latch_rst_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
